uart_tx_scheduler: RTL and testbench

//   Shares one UART transmit path (baud generator + serial tx pin) among N_REQ byte requesters.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_rr_arbiter.sv | 34 +++
 rtl/uart_tx_scheduler.sv | 131 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit scheduler.
//   state_t       : scheduler FSM states (IDLE, LOAD, SHIFT, DONE)
//   UART_IDLE_LVL : line level while no frame is being sent
//   frame_bits()  : bits per frame for a given payload width
//   FRAME_BITS    : frame length for the default 8-bit payload
// Build option: UART_TX_SCHED_PARITY_EN adds an even-parity bit to each frame.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    localparam logic UART_IDLE_LVL = 1'b1;

    function automatic int unsigned frame_bits(input int unsigned data_w);
`ifdef UART_TX_SCHED_PARITY_EN
        return data_w + 3;
`else
        return data_w + 2;
`endif
    endfunction

    localparam int unsigned FRAME_BITS = frame_bits(8);

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin search.
//   req   in  N_REQ          pending requests
//   ptr   in  clog2(N_REQ)   highest-priority index this round
//   found out 1              at least one request pending
//   grant out clog2(N_REQ)   first pending index at or after ptr (mod N_REQ)
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] grant
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    int unsigned idx;

    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = (32'(ptr) + i) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmit path among N_REQ byte requesters.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : per-requester byte pending (data held until accepted)
//   req_data    : packed payloads, requester i at [i*DATA_W +: DATA_W]
//   req_ready   : one-hot accept strobe
//   baud_start  : pulse that starts the baud generator
//   bit_end     : end-of-bit-period pulse from the baud generator
//   baud_busy   : baud generator running
//   tx          : serial line, idle high
//   busy        : scheduler not idle
//   grant_id    : current or last granted requester
//   tx_done     : full frame sent
//   frame_err   : frame aborted (baud generator stopped early)
// Build option: UART_TX_SCHED_PARITY_EN inserts even parity before the stop bit.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      baud_start,
    input  logic                      bit_end,
    input  logic                      baud_busy,
    output logic                      tx,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      tx_done,
    output logic                      frame_err
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned FB    = frame_bits(DATA_W);

    state_t              state, state_nxt;
    logic [FB-1:0]       shreg;
    logic [FB-1:0]       frame_load;
    logic [3:0]          bit_cnt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    ptr_next;
    logic                arb_found;
    logic [IDX_W-1:0]    arb_grant;
    logic [DATA_W-1:0]   data_g;

    uart_rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_arb (
        .req  (req_valid),
        .ptr  (rr_ptr),
        .found(arb_found),
        .grant(arb_grant)
    );

    assign data_g = req_data[arb_grant*DATA_W +: DATA_W];

`ifdef UART_TX_SCHED_PARITY_EN
    assign frame_load = {1'b1, ^data_g, data_g, 1'b0};
`else
    assign frame_load = {1'b1, data_g, 1'b0};
`endif

    assign ptr_next = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy     = (state != IDLE);

    // Outputs decode from state, so an asynchronous reset drives tx high at once.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        baud_start = 1'b0;
        tx         = UART_IDLE_LVL;
        tx_done    = 1'b0;
        frame_err  = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb_found) begin
                    req_ready[arb_grant] = 1'b1;
                    state_nxt            = LOAD;
                end
            end
            LOAD: begin
                baud_start = 1'b1;
                tx         = 1'b0;
                state_nxt  = SHIFT;
            end
            SHIFT: begin
                tx = shreg[0];
                if (bit_end) begin
                    if (bit_cnt == 4'(FB - 1))
                        state_nxt = DONE;
                end else if (!baud_busy) begin
                    frame_err = 1'b1;
                    tx        = UART_IDLE_LVL;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                tx_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '1;
            bit_cnt  <= '0;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && arb_found) begin
                grant_id <= arb_grant;
                shreg    <= frame_load;
                bit_cnt  <= '0;
            end else if (state == SHIFT && bit_end) begin
                shreg   <= {1'b1, shreg[FB-1:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            // Aborted frames advance the pointer exactly like completed ones.
            if (tx_done || frame_err)
                rr_ptr <= ptr_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed self-checking bench for uart_tx_scheduler.
// A behavioural baud generator (16 clk per bit) answers baud_start; the serial
// line is sampled mid-bit and compared against hand-computed frames.
module tb_uart_tx_scheduler;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int          PERIOD = 16;
`ifdef UART_TX_SCHED_PARITY_EN
    localparam int          FB     = 11;
`else
    localparam int          FB     = 10;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ*DATA_W-1:0]  req_data;
    logic [N_REQ-1:0]         req_ready;
    logic                     baud_start;
    logic                     bit_end;
    logic                     baud_busy;
    logic                     tx;
    logic                     busy;
    logic [1:0]               grant_id;
    logic                     tx_done;
    logic                     frame_err;

    int vectors     = 0;
    int miscompares = 0;

    // baud model / monitor state
    logic bon;
    int   bcnt;
    int   be_count;
    int   drop_after;
    int   done_cnt;
    int   err_cnt;
    int   viol;
    logic cap[$];

    uart_tx_scheduler #(
        .N_REQ (N_REQ),
        .DATA_W(DATA_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .baud_start(baud_start),
        .bit_end   (bit_end),
        .baud_busy (baud_busy),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id),
        .tx_done   (tx_done),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        bon       = 1'b0;
        bcnt      = 0;
        bit_end   = 1'b0;
        baud_busy = 1'b0;
    endtask

    // One clock: drive baud inputs at the falling edge, sample 1 ns later.
    task automatic tick();
        @(negedge clk);
        bit_end = 1'b0;
        if (baud_start) begin
            bon       = 1'b1;
            bcnt      = 0;
            baud_busy = 1'b1;
            be_count  = 0;
            cap.delete();
        end else if (tx_done) begin
            bon       = 1'b0;
            baud_busy = 1'b0;
        end else if (bon) begin
            bcnt++;
            if (bcnt == PERIOD / 2)
                cap.push_back(tx);
            if (bcnt == PERIOD) begin
                bcnt = 0;
                if (drop_after >= 0 && be_count == drop_after) begin
                    bon       = 1'b0;
                    baud_busy = 1'b0;
                end else begin
                    bit_end = 1'b1;
                    be_count++;
                end
            end
        end
        #1;
        if (tx_done)              done_cnt++;
        if (frame_err)            err_cnt++;
        if (!$onehot0(req_ready)) viol++;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (n < 400 && !(tx_done || frame_err)) begin
            tick();
            n++;
        end
        if (!(tx_done || frame_err))
            check("frame_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [15:0] captured();
        logic [15:0] v;
        v = '0;
        foreach (cap[i]) if (i < 16) v[i] = cap[i];
        return v;
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int d0, e0;
        drop_after = -1;
        done_cnt   = 0;
        err_cnt    = 0;
        viol       = 0;
        be_count   = 0;
        req_data   = '0;
        do_reset();
        rst_n = 1'b0;
        #1;
        // reset state
        check("rst_tx",        32'(tx),         32'd1);
        check("rst_ready",     32'(req_ready),  32'd0);
        check("rst_baud",      32'(baud_start), 32'd0);
        check("rst_busy",      32'(busy),       32'd0);
        check("rst_done",      32'(tx_done),    32'd0);
        check("rst_err",       32'(frame_err),  32'd0);
        check("rst_grant",     32'(grant_id),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: single request, A5 from requester 0
        req_data[0 +: 8] = 8'hA5;
        req_valid = 4'b0001;
        #1;
        check("t1_ready", 32'(req_ready), 32'b0001);
        tick();
        req_valid = 4'b0000;
        check("t1_start_tx",   32'(tx),         32'd0);
        check("t1_baud_start", 32'(baud_start), 32'd1);
        wait_frame();
`ifdef UART_TX_SCHED_PARITY_EN
        check("t1_frame", 32'(captured()), 32'h54A);
`else
        check("t1_frame", 32'(captured()), 32'h34A);
`endif
        check("t1_bits",  32'(be_count), 32'(FB));
        check("t1_done",  32'(done_cnt), 32'd1);
        check("t1_grant", 32'(grant_id), 32'd0);
        check("t1_stop_tx", 32'(tx), 32'd1);
        tick();
        check("t1_idle_tx", 32'(tx), 32'd1);

        // 2: all valid from reset, grants 0,1,2,3,0
        do_reset();
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        begin
            logic [1:0]  exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
            logic [15:0] exp_f [5] = '{16'h222, 16'h244, 16'h266, 16'h288, 16'h222};
            for (int f = 0; f < 5; f++) begin
                wait_frame();
                if (f == 4) req_valid = 4'b0000;
                check("t2_grant", 32'(grant_id), 32'(exp_g[f]));
`ifndef UART_TX_SCHED_PARITY_EN
                check("t2_frame", 32'(captured()), 32'(exp_f[f]));
`endif
                check("t2_stop_tx", 32'(tx), 32'd1);
                tick();
            end
        end
        check("t2_onehot", 32'(viol), 32'd0);

        // 3: requesters 0 and 2, pointer at 1 -> 2, 0 (wrap), 2
        req_valid = 4'b0101;
        begin
            logic [1:0] exp_g3 [3] = '{2'd2, 2'd0, 2'd2};
            for (int f = 0; f < 3; f++) begin
                wait_frame();
                if (f == 2) req_valid = 4'b0000;
                check("t3_grant", 32'(grant_id), 32'(exp_g3[f]));
                tick();
            end
        end

        // 4: baud generator stops after 4 bit_end pulses
        d0 = done_cnt;
        e0 = err_cnt;
        req_data[8 +: 8] = 8'h5A;
        drop_after = 4;
        req_valid  = 4'b0010;
        wait_frame();
        req_valid = 4'b0000;
        check("t4_grant",  32'(grant_id), 32'd1);
        check("t4_err",    32'(err_cnt - e0), 32'd1);
        check("t4_pulses", 32'(be_count), 32'd4);
        tick();
        drop_after = -1;
        check("t4_tx_after", 32'(tx),        32'd1);
        check("t4_busy",     32'(busy),      32'd0);
        check("t4_err_pulse",32'(frame_err), 32'd0);
        check("t4_no_done",  32'(done_cnt - d0), 32'd0);

        // 5: pointer advanced past aborted grant 1 -> grant 2; reset mid start bit
        req_data[16 +: 8] = 8'hC3;
        req_valid = 4'b0110;
        #1;
        check("t5_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        repeat (4) tick();
        check("t5_pre_tx",    32'(tx),       32'd0);
        check("t5_pre_grant", 32'(grant_id), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_tx",   32'(tx),   32'd1);
        check("t5_rst_busy", 32'(busy), 32'd0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        e0 = err_cnt;
        req_data[24 +: 8] = 8'h3C;
        req_valid = 4'b1000;
        wait_frame();
        req_valid = 4'b0000;
        check("t5_grant", 32'(grant_id), 32'd3);
`ifndef UART_TX_SCHED_PARITY_EN
        check("t5_frame", 32'(captured()), 32'h278);
`endif
        check("t5_done", 32'(done_cnt - d0), 32'd1);
        check("t5_err",  32'(err_cnt - e0),  32'd0);
        tick();

`ifdef UART_TX_SCHED_PARITY_EN
        // 6: parity bit for 8'h07 is 1; 11 bit periods
        req_data[0 +: 8] = 8'h07;
        req_valid = 4'b0001;
        wait_frame();
        req_valid = 4'b0000;
        check("t6_frame", 32'(captured()), 32'h60E);
        check("t6_bits",  32'(be_count),   32'd11);
        check("t6_grant", 32'(grant_id),   32'd0);
        tick();
`endif

        check("onehot_all", 32'(viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
